axi_lite_xbar_map_ctrl: RTL and testbench
=========================================

Name: axi_lite_xbar_map_ctrl

Overview:
Sits between the AXI4-Lite masters and the slave ports of the AXI4-Lite crossbar, and owns the crossbar's address map and default-port configuration. Software stages new rules into shadow registers, then issues a commit. On commit the block quiesces all slave ports (isolate, then drain), swaps shadow into active atomically, and releases traffic. This guarantees the crossbar never sees a map or default-port change while an Ax beat is unserved or a response is outstanding.

Parameters:
NoSlvPorts, 2, number of crossbar slave ports controlled.
NoMstPorts, 4, number of crossbar master ports (range of rule idx / default port).
NoAddrRules, 4, number of address rules.
MaxTrans, 8, max outstanding writes and max outstanding reads per slave port.
DrainTimeout, 1024, drain cycle budget; used only with the optional feature.
rule_t, axi_pkg::xbar_rule_64_t, rule type with idx, start_addr, end_addr.
axi_lite_req_t / axi_lite_rsp_t, logic, AXI4-Lite request/response structs.
MstIdxWidth, (NoMstPorts>1)?$clog2(NoMstPorts):1, dependent; do not override.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
slv_reqs_i  in  NoSlvPorts x axi_lite_req_t  requests from masters.
slv_resps_o  out  NoSlvPorts x axi_lite_rsp_t  responses to masters.
mst_reqs_o  out  NoSlvPorts x axi_lite_req_t  gated requests to crossbar slave ports.
mst_resps_i  in  NoSlvPorts x axi_lite_rsp_t  responses from crossbar.
cfg_wr_valid_i  in  1  shadow write strobe.
cfg_wr_ready_o  out  1  shadow write accepted (high only in IDLE).
cfg_wr_sel_i  in  1  0: rule write; 1: default-port write.
cfg_wr_idx_i  in  max(clog2(NoAddrRules),clog2(NoSlvPorts),1)  rule index or slave-port index.
cfg_rule_i  in  rule_t  rule data.
cfg_dflt_en_i  in  1  default enable data.
cfg_dflt_port_i  in  MstIdxWidth  default port data.
commit_req_i  in  1  request commit (held until ack).
commit_ack_o  out  1  one-cycle pulse at end of commit.
busy_o  out  1  high in any state other than IDLE.
addr_map_o  out  NoAddrRules x rule_t  active map to crossbar.
en_default_mst_port_o  out  NoSlvPorts  active default enables.
default_mst_port_o  out  NoSlvPorts x MstIdxWidth  active default ports.

Behaviour:
- Reset: shadow and active registers are '0, state IDLE, counters 0, commit_ack_o=0, busy_o=0, cfg_wr_ready_o=1. An all-zero map decodes everything to DECERR until the first commit.
- Passthrough: W, B, R and all payloads pass combinationally. AW/AR valid/ready are gated per port.
- Gate-lock: once an AW/AR valid has been presented downstream and not yet accepted, it stays presented until the handshake; a per-port, per-channel pending flag tracks this. Gating only blocks requests that have not yet been presented.
- Counters: per port, wr_cnt increments on downstream aw handshake and decrements on upstream b handshake; rd_cnt does the same with ar and r. A simultaneous increment and decrement leaves the count unchanged. A counter at MaxTrans blocks new AW/AR on that port. Width is $clog2(MaxTrans+1).
- Shadow writes are accepted only in IDLE. An out-of-range idx is accepted and ignored.
- FSM:
  - IDLE: on commit_req_i, go to ISOLATE; gating asserts in the same cycle.
  - ISOLATE: new AW/AR are blocked on all ports. Go to DRAIN when no pending flag is set.
  - DRAIN: wait until all wr_cnt and rd_cnt are 0, then go to APPLY.
  - APPLY: one cycle. Active <= shadow; commit_ack_o=1. Next state IDLE, and gating releases.
- Commit latency with an idle bus: 3 cycles from commit_req_i to commit_ack_o.
- commit_req_i still high in the cycle after ack starts a new commit. The requester must drop it on ack.
- Outputs addr_map_o and the default-port outputs change only on the APPLY edge.

Optional Feature:
- Macro AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN.
- When defined, adds a DRAIN cycle counter and an output err_o (1 bit, resets to 0). If DRAIN exceeds DrainTimeout cycles, the commit aborts: active is unchanged, err_o stays set until the next commit_req_i, and commit_ack_o pulses.
- When undefined, DRAIN waits indefinitely and there is no err_o port.

Decomposition:
- Package axi_lite_xbar_map_ctrl_pkg holds the state enum (IDLE, ISOLATE, DRAIN, APPLY) and the cfg_wr_sel encoding constants.
- Sub-module axi_lite_xbar_map_ctrl_cnt is instantiated once per port. It contains the wr/rd outstanding counters, the pending flags, and the gate logic. Its outputs are idle_o and gated valid/ready.

Test Plan:
- Write rule 0 = {idx 1, 0x1000, 0x2000}, default port 0 = {en 1, port 2}, then commit on an idle bus -> ack 3 cycles later; addr_map_o[0] matches; outputs are unchanged before the APPLY edge.
- Port 0 AW presented with aw_ready low, then commit -> AW held until accepted. Ack only after B returns. No new AW passes during ISOLATE or DRAIN.
- Port 1 has 3 reads outstanding and the R responses are delayed 20 cycles -> state remains DRAIN, and ack follows the last R handshake by exactly 2 cycles.
- 8 writes issued on port 0 without B -> 9th AW is blocked (aw_ready=0). One B returns -> the 9th is accepted.
- cfg_wr_valid_i asserted during DRAIN -> cfg_wr_ready_o=0 and the shadow is unchanged until IDLE.
- Reset asserted mid-DRAIN -> all outputs return to reset values asynchronously. With TIMEOUT_EN and DrainTimeout=16 and B withheld -> err_o=1, ack pulses, map unchanged.

Source files
------------

// File: rtl/axi_lite_xbar_map_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite crossbar address-map controller.
// Holds the commit FSM states, the cfg_wr_sel encoding and the default AXI4-Lite/rule types.
package axi_lite_xbar_map_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StIsolate, StDrain, StApply} state_e;

    localparam logic CfgSelRule = 1'b0;
    localparam logic CfgSelDflt = 1'b1;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axil_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axil_r_t;

    typedef struct packed {
        axil_ax_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } axil_rsp_t;

    // Index width that can address either a rule or a slave port, never below one bit.
    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? m : 1;
    endfunction

endpackage

// File: rtl/axi_lite_xbar_map_ctrl_cnt.sv
// Per-slave-port outstanding-transaction tracker and AW/AR gate.
// Ax requests already presented downstream stay presented until their handshake.
module axi_lite_xbar_map_ctrl_cnt
    import axi_lite_xbar_map_ctrl_pkg::*;
#(
    parameter int unsigned MaxTrans       = 8,
    parameter type         axi_lite_req_t = axil_req_t,
    parameter type         axi_lite_rsp_t = axil_rsp_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          gate_i,
    input  axi_lite_req_t slv_req_i,
    output axi_lite_rsp_t slv_rsp_o,
    output axi_lite_req_t mst_req_o,
    input  axi_lite_rsp_t mst_rsp_i,
    output logic          idle_o,
    output logic          pending_o
);

    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
    logic                aw_pend_q, ar_pend_q;
    logic                aw_block, ar_block;
    logic                aw_hs, ar_hs, b_hs, r_hs;

    assign aw_block = (gate_i || (wr_cnt_q == CntWidth'(MaxTrans))) && !aw_pend_q;
    assign ar_block = (gate_i || (rd_cnt_q == CntWidth'(MaxTrans))) && !ar_pend_q;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid && !aw_block;
        mst_req_o.ar_valid = slv_req_i.ar_valid && !ar_block;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && !aw_block;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && !ar_block;
    end

    assign aw_hs = mst_req_o.aw_valid && mst_rsp_i.aw_ready;
    assign ar_hs = mst_req_o.ar_valid && mst_rsp_i.ar_ready;
    assign b_hs  = mst_rsp_i.b_valid && slv_req_i.b_ready;
    assign r_hs  = mst_rsp_i.r_valid && slv_req_i.r_ready;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CntWidth'(1);
        end else if (!aw_hs && b_hs) begin
            wr_cnt_d = wr_cnt_q - CntWidth'(1);
        end
        if (ar_hs && !r_hs) begin
            rd_cnt_d = rd_cnt_q + CntWidth'(1);
        end else if (!ar_hs && r_hs) begin
            rd_cnt_d = rd_cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            aw_pend_q <= mst_req_o.aw_valid && !mst_rsp_i.aw_ready;
            ar_pend_q <= mst_req_o.ar_valid && !mst_rsp_i.ar_ready;
        end
    end

    assign pending_o = aw_pend_q || ar_pend_q;
    assign idle_o    = (wr_cnt_q == '0) && (rd_cnt_q == '0) && !pending_o;

endmodule

// File: rtl/axi_lite_xbar_map_ctrl.sv
// Owns the crossbar address map and default ports; commits shadow->active only on a quiet bus.
// Optional macro AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN adds a DRAIN timeout with err_o.
module axi_lite_xbar_map_ctrl
    import axi_lite_xbar_map_ctrl_pkg::*;
#(
    parameter int unsigned NoSlvPorts     = 2,
    parameter int unsigned NoMstPorts     = 4,
    parameter int unsigned NoAddrRules    = 4,
    parameter int unsigned MaxTrans       = 8,
    parameter int unsigned DrainTimeout   = 1024,
    parameter type         rule_t         = xbar_rule_64_t,
    parameter type         axi_lite_req_t = axil_req_t,
    parameter type         axi_lite_rsp_t = axil_rsp_t,
    parameter int unsigned MstIdxWidth    = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned CfgIdxWidth   = max_width($clog2(NoAddrRules), $clog2(NoSlvPorts))
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  axi_lite_req_t [NoSlvPorts-1:0]         slv_reqs_i,
    output axi_lite_rsp_t [NoSlvPorts-1:0]         slv_resps_o,
    output axi_lite_req_t [NoSlvPorts-1:0]         mst_reqs_o,
    input  axi_lite_rsp_t [NoSlvPorts-1:0]         mst_resps_i,
    input  logic                                   cfg_wr_valid_i,
    output logic                                   cfg_wr_ready_o,
    input  logic                                   cfg_wr_sel_i,
    input  logic [CfgIdxWidth-1:0]                 cfg_wr_idx_i,
    input  rule_t                                  cfg_rule_i,
    input  logic                                   cfg_dflt_en_i,
    input  logic [MstIdxWidth-1:0]                 cfg_dflt_port_i,
    input  logic                                   commit_req_i,
    output logic                                   commit_ack_o,
    output logic                                   busy_o,
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
    output logic                                   err_o,
`endif
    output rule_t [NoAddrRules-1:0]                addr_map_o,
    output logic [NoSlvPorts-1:0]                  en_default_mst_port_o,
    output logic [NoSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o
);

    state_e                                 state_q;
    logic                                   ack_q, busy_q, cfg_rdy_q;
    logic                                   gate, apply;
    logic [NoSlvPorts-1:0]                  port_idle, port_pending;
    rule_t [NoAddrRules-1:0]                shadow_map_q, active_map_q;
    logic [NoSlvPorts-1:0]                  shadow_en_q, active_en_q;
    logic [NoSlvPorts-1:0][MstIdxWidth-1:0] shadow_port_q, active_port_q;

    // Gate from the cycle the commit is requested, so nothing new slips in before ISOLATE.
    assign gate = (state_q != StIdle) || commit_req_i;

    for (genvar i = 0; i < NoSlvPorts; i++) begin : g_port
        axi_lite_xbar_map_ctrl_cnt #(
            .MaxTrans       (MaxTrans),
            .axi_lite_req_t (axi_lite_req_t),
            .axi_lite_rsp_t (axi_lite_rsp_t)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .gate_i    (gate),
            .slv_req_i (slv_reqs_i[i]),
            .slv_rsp_o (slv_resps_o[i]),
            .mst_req_o (mst_reqs_o[i]),
            .mst_rsp_i (mst_resps_i[i]),
            .idle_o    (port_idle[i]),
            .pending_o (port_pending[i])
        );
    end

`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
    localparam int unsigned DrainCntWidth = $clog2(DrainTimeout + 1);

    logic                     err_q;
    logic [DrainCntWidth-1:0] drain_cnt_q;

    assign err_o = err_q;
    assign apply = (state_q == StApply) && !err_q;
`else
    assign apply = (state_q == StApply);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            cfg_rdy_q   <= 1'b1;
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
            err_q       <= 1'b0;
            drain_cnt_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (commit_req_i) begin
                        state_q   <= StIsolate;
                        busy_q    <= 1'b1;
                        cfg_rdy_q <= 1'b0;
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                StIsolate: begin
                    if (!(|port_pending)) begin
                        state_q     <= StDrain;
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
                        drain_cnt_q <= '0;
`endif
                    end
                end
                StDrain: begin
                    if (&port_idle) begin
                        state_q <= StApply;
                        ack_q   <= 1'b1;
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
                    end else if (drain_cnt_q == DrainCntWidth'(DrainTimeout - 1)) begin
                        // Abort: ack without touching the active map.
                        state_q <= StApply;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DrainCntWidth'(1);
`endif
                    end
                end
                StApply: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    cfg_rdy_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_map_q  <= '0;
            shadow_en_q   <= '0;
            shadow_port_q <= '0;
        end else if (cfg_wr_valid_i && cfg_rdy_q) begin
            if (cfg_wr_sel_i == CfgSelRule) begin
                for (int unsigned i = 0; i < NoAddrRules; i++) begin
                    if (32'(cfg_wr_idx_i) == i) begin
                        shadow_map_q[i] <= cfg_rule_i;
                    end
                end
            end else begin
                for (int unsigned i = 0; i < NoSlvPorts; i++) begin
                    if (32'(cfg_wr_idx_i) == i) begin
                        shadow_en_q[i]   <= cfg_dflt_en_i;
                        shadow_port_q[i] <= cfg_dflt_port_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_map_q  <= '0;
            active_en_q   <= '0;
            active_port_q <= '0;
        end else if (apply) begin
            active_map_q  <= shadow_map_q;
            active_en_q   <= shadow_en_q;
            active_port_q <= shadow_port_q;
        end
    end

    assign commit_ack_o          = ack_q;
    assign busy_o                = busy_q;
    assign cfg_wr_ready_o        = cfg_rdy_q;
    assign addr_map_o            = active_map_q;
    assign en_default_mst_port_o = active_en_q;
    assign default_mst_port_o    = active_port_q;

endmodule

// File: tb/tb_axi_lite_xbar_map_ctrl.sv
// Directed bench for axi_lite_xbar_map_ctrl: commit timing, gate-lock, drain, MaxTrans, reset.
module tb_axi_lite_xbar_map_ctrl;
    import axi_lite_xbar_map_ctrl_pkg::*;

    localparam int unsigned NoSlvPorts  = 2;
    localparam int unsigned NoAddrRules = 4;
    localparam int unsigned MstIdxWidth = 2;
    localparam int unsigned CfgIdxWidth = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    axil_req_t [NoSlvPorts-1:0]             slv_reqs;
    axil_rsp_t [NoSlvPorts-1:0]             slv_resps;
    axil_req_t [NoSlvPorts-1:0]             mst_reqs;
    axil_rsp_t [NoSlvPorts-1:0]             mst_resps;
    logic                                   cfg_wr_valid_i, cfg_wr_ready_o, cfg_wr_sel_i;
    logic [CfgIdxWidth-1:0]                 cfg_wr_idx_i;
    xbar_rule_64_t                          cfg_rule_i;
    logic                                   cfg_dflt_en_i;
    logic [MstIdxWidth-1:0]                 cfg_dflt_port_i;
    logic                                   commit_req_i, commit_ack_o, busy_o;
    xbar_rule_64_t [NoAddrRules-1:0]        addr_map_o;
    logic [NoSlvPorts-1:0]                  en_default_mst_port_o;
    logic [NoSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o;
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
    logic                                   err_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;

    xbar_rule_64_t rule_a, rule_b, rule_c;

    always #5 clk_i = ~clk_i;

    axi_lite_xbar_map_ctrl #(
        .NoSlvPorts   (2),
        .NoMstPorts   (4),
        .NoAddrRules  (4),
        .MaxTrans     (8),
        .DrainTimeout (16)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .slv_reqs_i            (slv_reqs),
        .slv_resps_o           (slv_resps),
        .mst_reqs_o            (mst_reqs),
        .mst_resps_i           (mst_resps),
        .cfg_wr_valid_i        (cfg_wr_valid_i),
        .cfg_wr_ready_o        (cfg_wr_ready_o),
        .cfg_wr_sel_i          (cfg_wr_sel_i),
        .cfg_wr_idx_i          (cfg_wr_idx_i),
        .cfg_rule_i            (cfg_rule_i),
        .cfg_dflt_en_i         (cfg_dflt_en_i),
        .cfg_dflt_port_i       (cfg_dflt_port_i),
        .commit_req_i          (commit_req_i),
        .commit_ack_o          (commit_ack_o),
        .busy_o                (busy_o),
`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
        .err_o                 (err_o),
`endif
        .addr_map_o            (addr_map_o),
        .en_default_mst_port_o (en_default_mst_port_o),
        .default_mst_port_o    (default_mst_port_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds commit_req_i until ack or budget; lat = cycles to ack, -1 if budget expired.
    task automatic wait_ack(input int budget, output int lat_o);
        lat_o = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (commit_ack_o === 1'b1) begin
                lat_o = i;
                break;
            end
        end
        commit_req_i = 1'b0;
    endtask

    task automatic cfg_rule(input logic [CfgIdxWidth-1:0] idx, input xbar_rule_64_t r);
        cfg_wr_valid_i = 1'b1;
        cfg_wr_sel_i   = CfgSelRule;
        cfg_wr_idx_i   = idx;
        cfg_rule_i     = r;
        tick();
        cfg_wr_valid_i = 1'b0;
    endtask

    task automatic cfg_dflt(input logic [CfgIdxWidth-1:0] idx, input logic en,
                            input logic [MstIdxWidth-1:0] port);
        cfg_wr_valid_i  = 1'b1;
        cfg_wr_sel_i    = CfgSelDflt;
        cfg_wr_idx_i    = idx;
        cfg_dflt_en_i   = en;
        cfg_dflt_port_i = port;
        tick();
        cfg_wr_valid_i = 1'b0;
    endtask

    initial begin
        slv_reqs        = '0;
        mst_resps       = '0;
        cfg_wr_valid_i  = 1'b0;
        cfg_wr_sel_i    = 1'b0;
        cfg_wr_idx_i    = '0;
        cfg_rule_i      = '0;
        cfg_dflt_en_i   = 1'b0;
        cfg_dflt_port_i = '0;
        commit_req_i    = 1'b0;
        rule_a = '{idx: 32'd1, start_addr: 64'h1000, end_addr: 64'h2000};
        rule_b = '{idx: 32'd3, start_addr: 64'h4000, end_addr: 64'h5000};
        rule_c = '{idx: 32'd2, start_addr: 64'h8000, end_addr: 64'h9000};

        #12;
        check("rst_busy", busy_o, 1'b0);
        check("rst_cfg_ready", cfg_wr_ready_o, 1'b1);
        check("rst_ack", commit_ack_o, 1'b0);
        check("rst_map", addr_map_o, '0);
        check("rst_dflt_en", en_default_mst_port_o, 2'b00);
        check("rst_dflt_port", default_mst_port_o, 4'h0);
        rst_ni = 1'b1;
        tick();

        // Idle-bus commit: ack 3 cycles after request, outputs change only after APPLY.
        cfg_rule(2'd0, rule_a);
        cfg_dflt(2'd0, 1'b1, 2'd2);
        cfg_dflt(2'd3, 1'b1, 2'd3);
        check("shadow_hidden", addr_map_o[0], '0);
        commit_req_i = 1'b1;
        tick();
        check("c1_ack", commit_ack_o, 1'b0);
        check("c1_busy", busy_o, 1'b1);
        tick();
        check("c2_ack", commit_ack_o, 1'b0);
        tick();
        check("c3_ack", commit_ack_o, 1'b1);
        check("c3_map_old", addr_map_o[0], '0);
        commit_req_i = 1'b0;
        tick();
        check("c4_ack", commit_ack_o, 1'b0);
        check("c4_busy", busy_o, 1'b0);
        check("c4_map0", addr_map_o[0], rule_a);
        check("c4_dflt_en", en_default_mst_port_o, 2'b01);
        check("c4_dflt_port", default_mst_port_o, 4'b0010);

        // Gate-lock: a presented AW stays presented through ISOLATE; new AW is blocked.
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].aw.addr  = 32'h1234;
        #1;
        check("aw0_pass", mst_reqs[0].aw_valid, 1'b1);
        tick();
        commit_req_i         = 1'b1;
        slv_reqs[1].aw_valid = 1'b1;
        #1;
        check("aw0_locked", mst_reqs[0].aw_valid, 1'b1);
        check("aw1_gated", mst_reqs[1].aw_valid, 1'b0);
        ticks(3);
        check("iso_ack", commit_ack_o, 1'b0);
        check("iso_aw0_held", mst_reqs[0].aw_valid, 1'b1);
        mst_resps[0].aw_ready = 1'b1;
        tick();
        slv_reqs[0].aw_valid  = 1'b0;
        mst_resps[0].aw_ready = 1'b0;
        ticks(4);
        check("drain_ack", commit_ack_o, 1'b0);
        check("drain_aw1_gated", mst_reqs[1].aw_valid, 1'b0);
        mst_resps[0].b_valid = 1'b1;
        slv_reqs[0].b_ready  = 1'b1;
        tick();
        mst_resps[0].b_valid = 1'b0;
        slv_reqs[0].b_ready  = 1'b0;
        check("b_plus1_ack", commit_ack_o, 1'b0);
        tick();
        check("b_plus2_ack", commit_ack_o, 1'b1);
        commit_req_i = 1'b0;
        tick();
        check("aw1_released", mst_reqs[1].aw_valid, 1'b1);
        mst_resps[1].aw_ready = 1'b1;
        tick();
        slv_reqs[1].aw_valid  = 1'b0;
        mst_resps[1].aw_ready = 1'b0;
        mst_resps[1].b_valid  = 1'b1;
        slv_reqs[1].b_ready   = 1'b1;
        tick();
        mst_resps[1].b_valid  = 1'b0;
        slv_reqs[1].b_ready   = 1'b0;

        // Three reads outstanding on port 1; shadow writes refused while draining.
        slv_reqs[1].ar_valid  = 1'b1;
        mst_resps[1].ar_ready = 1'b1;
        ticks(3);
        slv_reqs[1].ar_valid  = 1'b0;
        mst_resps[1].ar_ready = 1'b0;
        cfg_rule(2'd1, rule_b);
        commit_req_i = 1'b1;
        ticks(3);
        cfg_wr_valid_i = 1'b1;
        cfg_wr_sel_i   = CfgSelRule;
        cfg_wr_idx_i   = 2'd2;
        cfg_rule_i     = rule_c;
        #1;
        check("drain_cfg_ready", cfg_wr_ready_o, 1'b0);
        ticks(17);
        check("rd_drain_ack", commit_ack_o, 1'b0);
        check("rd_drain_busy", busy_o, 1'b1);
        cfg_wr_valid_i = 1'b0;
        mst_resps[1].r_valid = 1'b1;
        slv_reqs[1].r_ready  = 1'b1;
        ticks(3);
        mst_resps[1].r_valid = 1'b0;
        slv_reqs[1].r_ready  = 1'b0;
        check("r_plus1_ack", commit_ack_o, 1'b0);
        tick();
        check("r_plus2_ack", commit_ack_o, 1'b1);
        commit_req_i = 1'b0;
        tick();
        check("rd_map1", addr_map_o[1], rule_b);
        check("rd_map2_untouched", addr_map_o[2], '0);
        check("rd_map0_kept", addr_map_o[0], rule_a);
        check("rd_cfg_ready", cfg_wr_ready_o, 1'b1);

        // MaxTrans: 8 writes fill port 0, the 9th waits for one B.
        slv_reqs[0].aw_valid  = 1'b1;
        mst_resps[0].aw_ready = 1'b1;
        ticks(8);
        check("max_slv_aw_ready", slv_resps[0].aw_ready, 1'b0);
        check("max_mst_aw_valid", mst_reqs[0].aw_valid, 1'b0);
        tick();
        check("max_still_blocked", slv_resps[0].aw_ready, 1'b0);
        mst_resps[0].b_valid = 1'b1;
        slv_reqs[0].b_ready  = 1'b1;
        tick();
        mst_resps[0].b_valid = 1'b0;
        slv_reqs[0].b_ready  = 1'b0;
        #1;
        check("max_9th_ready", slv_resps[0].aw_ready, 1'b1);
        check("max_9th_valid", mst_reqs[0].aw_valid, 1'b1);
        tick();
        slv_reqs[0].aw_valid  = 1'b0;
        mst_resps[0].aw_ready = 1'b0;
        mst_resps[0].b_valid  = 1'b1;
        slv_reqs[0].b_ready   = 1'b1;
        ticks(8);
        mst_resps[0].b_valid  = 1'b0;
        slv_reqs[0].b_ready   = 1'b0;
        commit_req_i = 1'b1;
        wait_ack(10, lat);
        check("max_drained_lat", lat, 3);
        tick();

        // Asynchronous reset while DRAIN waits on a B.
        slv_reqs[0].aw_valid  = 1'b1;
        mst_resps[0].aw_ready = 1'b1;
        tick();
        slv_reqs[0].aw_valid  = 1'b0;
        mst_resps[0].aw_ready = 1'b0;
        commit_req_i = 1'b1;
        ticks(4);
        check("pre_rst_busy", busy_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 1'b0);
        check("arst_cfg_ready", cfg_wr_ready_o, 1'b1);
        check("arst_map0", addr_map_o[0], '0);
        check("arst_dflt_en", en_default_mst_port_o, 2'b00);
        check("arst_dflt_port", default_mst_port_o, 4'h0);
        check("arst_ack", commit_ack_o, 1'b0);
        commit_req_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

`ifdef AXI_LITE_XBAR_MAP_CTRL_TIMEOUT_EN
        // Drain timeout: B withheld, commit aborts with err_o and the map untouched.
        cfg_rule(2'd0, rule_a);
        slv_reqs[0].aw_valid  = 1'b1;
        mst_resps[0].aw_ready = 1'b1;
        tick();
        slv_reqs[0].aw_valid  = 1'b0;
        mst_resps[0].aw_ready = 1'b0;
        commit_req_i = 1'b1;
        wait_ack(40, lat);
        check("to_ack", commit_ack_o, 1'b1);
        check("to_err", err_o, 1'b1);
        tick();
        check("to_err_held", err_o, 1'b1);
        check("to_map_kept", addr_map_o[0], '0);
        mst_resps[0].b_valid = 1'b1;
        slv_reqs[0].b_ready  = 1'b1;
        tick();
        mst_resps[0].b_valid = 1'b0;
        slv_reqs[0].b_ready  = 1'b0;
        commit_req_i = 1'b1;
        tick();
        check("to_err_cleared", err_o, 1'b0);
        wait_ack(10, lat);
        tick();
        check("to_retry_map", addr_map_o[0], rule_a);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
